// File: rtl/fpu_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_arb_pkg
//  Description : Shared types and constants for the fpu_arbiter slice:
//                sequencer state encoding, the add opcode and default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_arb_pkg;

  // Sequencer states: accept, hold operands on the FPU, present the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // FloatALUop value for addition; also the idle value driven to the FPU.
  localparam logic [2:0] OP_ADD = 3'd0;

  // Default operand/result and opcode widths (IEEE-754 single, 3-bit op).
  localparam int DEF_DATA_W = 32;
  localparam int DEF_OP_W   = 3;

endpackage : fpu_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-request round-robin grant logic. A lone request wins
//                outright; when both request, the priority pointer decides.
//                Output is one-hot (or zero when disabled / nothing valid).
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
  input  logic [1:0] req_valid,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] grant
);

  // Select at most one winner; a tie is broken by the pointer.
  always_comb begin
    grant = 2'b00;
    if (en) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = prio ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/fpu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_arbiter
//  Description : Sequencer and two-way round-robin arbiter sharing one
//                combinational FP coprocessor between two requesters.
//                Operands are registered onto the FPU, held for EXEC_CYCLES,
//                then the result is returned on the originating rsp port.
//                Optional macro FPU_ARB_PERF_EN adds saturating grant/stall
//                performance counters (perf_grant0, perf_grant1, perf_stall).
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int OP_W        = DEF_OP_W,
  parameter int EXEC_CYCLES = 1
`ifdef FPU_ARB_PERF_EN
  , parameter int PERF_W    = 16
`endif
) (
  input  logic              clk,
  input  logic              reset,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  // responses
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  // coprocessor1 interface
  output logic [DATA_W-1:0] fpu_data1,
  output logic [DATA_W-1:0] fpu_data2,
  output logic [OP_W-1:0]   fpu_op,
  input  logic [DATA_W-1:0] fpu_res,
  output logic              busy
`ifdef FPU_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_grant0,
  output logic [PERF_W-1:0] perf_grant1,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  // Settle counter wide enough to hold EXEC_CYCLES-1 (at least one bit).
  localparam int                CNT_W    = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(EXEC_CYCLES - 1);

  state_t              state;
  state_t              state_next;
  logic                prio;      // 0: req0 favoured on a tie, 1: req1
  logic                owner;     // requester that owns the in-flight op
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   result;
  logic [1:0]          grant;
  logic                accept;
  logic                rsp_hs;

  rr_arb2 u_rr_arb2 (
    .req_valid ({req1_valid, req0_valid}),
    .prio      (prio),
    .en        (state == IDLE),
    .grant     (grant)
  );

  // Grant only goes to a valid requester, so any grant is an accept.
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign accept     = |grant;
  assign rsp_hs     = (state == RESP) && (owner ? rsp1_ready : rsp0_ready);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state decode and response/busy outputs.
  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp0_data  = '0;
    rsp1_data  = '0;
    case (state)
      IDLE: if (accept) state_next = EXEC;
      EXEC: if (cnt == '0) state_next = RESP;
      RESP: begin
        rsp0_valid = ~owner;
        rsp1_valid = owner;
        rsp0_data  = owner ? '0 : result;
        rsp1_data  = owner ? result : '0;
        if (rsp_hs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, settle countdown, result capture and pointer update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpu_data1 <= '0;
      fpu_data2 <= '0;
      fpu_op    <= OP_W'(OP_ADD);
      owner     <= 1'b0;
      cnt       <= '0;
      result    <= '0;
      prio      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            fpu_data1 <= grant[1] ? req1_a  : req0_a;
            fpu_data2 <= grant[1] ? req1_b  : req0_b;
            fpu_op    <= grant[1] ? req1_op : req0_op;
            owner     <= grant[1];
            cnt       <= CNT_INIT;
          end
        end
        EXEC: begin
          if (cnt == '0) result <= fpu_res;
          else           cnt    <= cnt - CNT_W'(1);
        end
        RESP: begin
          // Last-served requester drops to lowest priority.
          if (rsp_hs) prio <= ~owner;
        end
        default: ;
      endcase
    end
  end

`ifdef FPU_ARB_PERF_EN
  logic stall_now;
  assign stall_now = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

  // Saturating accept and stall counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_stall  <= '0;
    end else begin
      if (grant[0] && (perf_grant0 != '1)) perf_grant0 <= perf_grant0 + PERF_W'(1);
      if (grant[1] && (perf_grant1 != '1)) perf_grant1 <= perf_grant1 + PERF_W'(1);
      if (stall_now && (perf_stall != '1)) perf_stall  <= perf_stall  + PERF_W'(1);
    end
  end
`endif

endmodule : fpu_arbiter
`default_nettype wire
